// File: rtl/ysyx_23060184_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, the bus response code
// and the fault cause codes reported to the rest of the core.
package ysyx_23060184_fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_AR      = 3'd0,
        S_R       = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT_WB = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int FAULT_CAUSE_LENGTH = 2;
    typedef logic [FAULT_CAUSE_LENGTH-1:0] fault_cause_t;

    localparam fault_cause_t FAULT_NONE     = 2'd0;
    localparam fault_cause_t FAULT_BUS      = 2'd1;
    localparam fault_cause_t FAULT_MISALIGN = 2'd2;
    localparam fault_cause_t FAULT_TIMEOUT  = 2'd3;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060184_fetch_unit_if.sv
// Fetch-stage port bundle: AXI4-Lite-style read channel, decode handshake,
// writeback feedback and fault/status outputs.
interface ysyx_23060184_fetch_unit_if
    import ysyx_23060184_fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] Inst;
    logic [DATA_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] PCPlus4;
    logic                  Ivalid;
    logic                  Dready;
    logic                  Wvalid;
    logic [DATA_WIDTH-1:0] NextPC;
    logic                  Fault;
    fault_cause_t          FaultCause;
    logic [DATA_WIDTH-1:0] FetchCnt;

    modport master (
        output araddr, arvalid, rready, Inst, PC, PCPlus4, Ivalid,
               Fault, FaultCause, FetchCnt,
        input  arready, rdata, rresp, rvalid, Dready, Wvalid, NextPC
    );

    modport slave (
        input  araddr, arvalid, rready, Inst, PC, PCPlus4, Ivalid,
               Fault, FaultCause, FetchCnt,
        output arready, rdata, rresp, rvalid, Dready, Wvalid, NextPC
    );
endinterface

// File: rtl/ysyx_23060184_fetch_unit.sv
// Instruction fetch: one bus read per retired instruction, held for decode until
// Dready, then waits for writeback's NextPC. Bus/alignment/timeout errors park it in S_FAULT.
module ysyx_23060184_fetch_unit
    import ysyx_23060184_fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h8000_0000),
    parameter int                    TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rstn,
    ysyx_23060184_fetch_unit_if.master bus
);

    localparam int              TW          = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0]   TIMEOUT_VAL = TW'(TIMEOUT);

    state_t                state;
    logic [TW-1:0]         timer;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic [DATA_WIDTH-1:0] fetch_cnt_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  ivalid_q;
    logic                  fault_q;
    fault_cause_t          cause_q;

    logic waiting;
    logic timeout_hit;

    // The out-of-reset S_AR cycle has arvalid low, so it is not counted as waiting.
    assign waiting     = ((state == S_AR) && arvalid_q) || (state == S_R);
    assign timeout_hit = (TIMEOUT != 0) && (timer == TIMEOUT_VAL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_AR;
            timer       <= '0;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            fetch_cnt_q <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ivalid_q    <= 1'b0;
            fault_q     <= 1'b0;
            cause_q     <= FAULT_NONE;
        end else begin
            timer <= waiting ? timer + 1'b1 : '0;
            case (state)
                S_AR: begin
                    if (arvalid_q && bus.arready) begin
                        state     <= S_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        timer     <= '0;
                    end else if (waiting && timeout_hit) begin
                        state     <= S_FAULT;
                        arvalid_q <= 1'b0;
                        fault_q   <= 1'b1;
                        cause_q   <= FAULT_TIMEOUT;
                        timer     <= '0;
                    end else begin
                        arvalid_q <= 1'b1;
                    end
                end
                S_R: begin
                    if (bus.rvalid) begin
                        rready_q <= 1'b0;
                        timer    <= '0;
                        if (bus.rresp == RESP_OKAY) begin
                            inst_q   <= bus.rdata;
                            ivalid_q <= 1'b1;
                            state    <= S_ISSUE;
                        end else begin
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                            cause_q <= FAULT_BUS;
                        end
                    end else if (timeout_hit) begin
                        state    <= S_FAULT;
                        rready_q <= 1'b0;
                        fault_q  <= 1'b1;
                        cause_q  <= FAULT_TIMEOUT;
                        timer    <= '0;
                    end
                end
                S_ISSUE: begin
                    if (bus.Dready) begin
                        ivalid_q    <= 1'b0;
                        fetch_cnt_q <= fetch_cnt_q + 1'b1;
                        state       <= S_WAIT_WB;
                    end
                end
                S_WAIT_WB: begin
                    if (bus.Wvalid) begin
                        if (word_aligned(bus.NextPC[1:0])) begin
                            pc_q      <= bus.NextPC;
                            arvalid_q <= 1'b1;
                            state     <= S_AR;
                        end else begin
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                            cause_q <= FAULT_MISALIGN;
                        end
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state     <= S_FAULT;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    ivalid_q  <= 1'b0;
                    fault_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.araddr     = pc_q;
    assign bus.arvalid    = arvalid_q;
    assign bus.rready     = rready_q;
    assign bus.Inst       = inst_q;
    assign bus.PC         = pc_q;
    assign bus.PCPlus4    = pc_q + DATA_WIDTH'(4);
    assign bus.Ivalid     = ivalid_q;
    assign bus.Fault      = fault_q;
    assign bus.FaultCause = cause_q;
    assign bus.FetchCnt   = fetch_cnt_q;

endmodule
